// File: rtl/fp_align_pkg.sv
// Shared constants, state encodings and operand layout for the FP adder alignment stage.
package fp_align_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int SIG_W  = 24;
    localparam int GRS_W  = 3;
    localparam int MANT_W = SIG_W + GRS_W;
    localparam int CNT_W  = 5;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CMP   = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Denormals share the minimum normal exponent for alignment purposes.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

endpackage

// File: rtl/Complement2s.sv
// 8-bit two's-complement negation.
module Complement2s (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = ~din + 8'd1;

endmodule

// File: rtl/fp_sticky_shr.sv
// Combinational right shift by 0..2^SH_W-1; every bit dropped off the bottom,
// plus the old bit 0, is ORed into the new bit 0.
module fp_sticky_shr #(
    parameter int W    = 27,
    parameter int SH_W = 5
) (
    input  logic [W-1:0]    din,
    input  logic [SH_W-1:0] sh,
    output logic [W-1:0]    dout
);

    logic [W-1:0] mask;
    logic         lost;

    always_comb begin
        mask = '0;
        for (int i = 0; i < W; i++) begin
            mask[i] = (i < int'(sh));
        end
    end

    assign lost = |(din & mask);
    assign dout = (din >> sh) | {{(W-1){1'b0}}, lost};

endmodule

// File: rtl/fp_exp_align.sv
// FP adder alignment stage: orders operands by magnitude, computes the exponent
// difference and iteratively right-shifts the smaller significand with sticky.
module fp_exp_align
    import fp_align_pkg::*;
#(
    parameter int SHIFT_STEP = 4,
    parameter int MAX_SHIFT  = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        big_sign,
    output logic        eff_sub,
    output logic [7:0]  big_exp,
    output logic [23:0] big_mant,
    output logic [26:0] small_mant,
    output logic [7:0]  exp_diff,
    output logic        special
);

    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(SHIFT_STEP);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_SHIFT);
    localparam logic [EXP_W-1:0] MAX8   = EXP_W'(MAX_SHIFT);

    logic [1:0]       state;
    fp32_t            opa, opb;
    logic [CNT_W-1:0] cnt;

    // Compare-stage datapath, evaluated from the captured operands
    fp32_t             big, sml;
    logic              a_ge;
    logic [EXP_W-1:0]  e_big, e_sml, e_sml_neg, diff;
    logic [CNT_W-1:0]  cnt_init;
    logic [MANT_W-1:0] sml_mant;

    assign a_ge  = {opa.exp, opa.frac} >= {opb.exp, opb.frac};
    assign big   = a_ge ? opa : opb;
    assign sml   = a_ge ? opb : opa;
    assign e_big = eff_exp(big.exp);
    assign e_sml = eff_exp(sml.exp);

    Complement2s u_neg (
        .din  (e_sml),
        .dout (e_sml_neg)
    );

    // Ordering guarantees e_big >= e_sml, so the 8-bit sum never wraps.
    assign diff     = e_big + e_sml_neg;
    assign cnt_init = (diff > MAX8) ? MAX_C : diff[CNT_W-1:0];
    assign sml_mant = {(sml.exp != '0), sml.frac, {GRS_W{1'b0}}};

    // Shift-stage datapath
    logic [CNT_W-1:0]  step;
    logic [MANT_W-1:0] shifted;

    assign step = (cnt > STEP_C) ? STEP_C : cnt;

    fp_sticky_shr #(
        .W    (MANT_W),
        .SH_W (CNT_W)
    ) u_shr (
        .din  (small_mant),
        .sh   (step),
        .dout (shifted)
    );

    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            opa        <= '0;
            opb        <= '0;
            cnt        <= '0;
            big_sign   <= 1'b0;
            eff_sub    <= 1'b0;
            big_exp    <= '0;
            big_mant   <= '0;
            small_mant <= '0;
            exp_diff   <= '0;
            special    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= b;
                        state <= CMP;
                    end
                end
                CMP: begin
                    big_sign   <= big.sign;
                    eff_sub    <= opa.sign ^ opb.sign;
                    big_exp    <= e_big;
                    big_mant   <= {(big.exp != '0), big.frac};
                    small_mant <= sml_mant;
                    exp_diff   <= diff;
                    special    <= (opa.exp == '1) || (opb.exp == '1);
                    cnt        <= cnt_init;
                    state      <= (cnt_init != '0) ? SHIFT : DONE;
                end
                SHIFT: begin
                    small_mant <= shifted;
                    cnt        <= cnt - step;
                    if (cnt == step) state <= DONE;
                end
                default: begin
                    if (out_ready) state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_exp_align.sv
// Directed bench for fp_exp_align: hand-computed vectors, latency, hold and reset abort.
module tb_fp_exp_align;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [31:0] a, b;
    logic        out_valid, out_ready;
    logic        big_sign, eff_sub, special;
    logic [7:0]  big_exp, exp_diff;
    logic [23:0] big_mant;
    logic [26:0] small_mant;

    int n_chk = 0;
    int n_err = 0;
    int lat;

    fp_exp_align #(.SHIFT_STEP(4), .MAX_SHIFT(27)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .big_sign   (big_sign),
        .eff_sub    (eff_sub),
        .big_exp    (big_exp),
        .big_mant   (big_mant),
        .small_mant (small_mant),
        .exp_diff   (exp_diff),
        .special    (special)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Accept one pair, then count cycles (accept cycle = 0) until out_valid.
    task automatic send(input logic [31:0] va, input logic [31:0] vb);
        check("in_ready_before_send", {31'b0, in_ready}, 32'd1);
        a = va; b = vb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic expect_res(input string tag, input int el, input logic bs, input logic es,
                              input logic [7:0] be, input logic [23:0] bm, input logic [26:0] sm,
                              input logic [7:0] ed, input logic sp);
        check({tag, "_latency"},  lat, el);
        check({tag, "_big_sign"}, {31'b0, big_sign}, {31'b0, bs});
        check({tag, "_eff_sub"},  {31'b0, eff_sub}, {31'b0, es});
        check({tag, "_big_exp"},  {24'b0, big_exp}, {24'b0, be});
        check({tag, "_big_mant"}, {8'b0, big_mant}, {8'b0, bm});
        check({tag, "_small"},    {5'b0, small_mant}, {5'b0, sm});
        check({tag, "_exp_diff"}, {24'b0, exp_diff}, {24'b0, ed});
        check({tag, "_special"},  {31'b0, special}, {31'b0, sp});
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready}, 32'd0);
        check("rst_small",     {5'b0, small_mant}, 32'd0);
        check("rst_exp_diff",  {24'b0, exp_diff}, 32'd0);
        check("rst_big_mant",  {8'b0, big_mant}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Equal operands: tie goes to a, no shift
        send(32'h3F800000, 32'h3F800000);
        expect_res("t1", 2, 1'b0, 1'b0, 8'h7F, 24'h800000, 27'h4000000, 8'h00, 1'b0);
        handshake("t1");

        send(32'h3F800000, 32'h3F000000);
        expect_res("t2", 3, 1'b0, 1'b0, 8'h7F, 24'h800000, 27'h2000000, 8'h01, 1'b0);
        handshake("t2");

        // b larger magnitude: swap
        send(32'h3F000000, 32'hBF800000);
        expect_res("t3", 3, 1'b1, 1'b1, 8'h7F, 24'h800000, 27'h2000000, 8'h01, 1'b0);
        handshake("t3");

        // diff 40 clamps to 27 shifts -> sticky only
        send(32'h3F800000, 32'h2B800000);
        expect_res("t4", 9, 1'b0, 1'b0, 8'h7F, 24'h800000, 27'h0000001, 8'h28, 1'b0);
        handshake("t4");

        // diff 5: one full step of 4 then a step of 1; sticky must catch the low 1
        send(32'h3F800000, 32'h3D000001);
        expect_res("stk", 4, 1'b0, 1'b0, 8'h7F, 24'h800000, 27'h0200001, 8'h05, 1'b0);
        handshake("stk");

        // Clamp with zero small significand
        send(32'h3F800000, 32'h00000000);
        expect_res("clz", 9, 1'b0, 1'b0, 8'h7F, 24'h800000, 27'h0000000, 8'h7E, 1'b0);
        handshake("clz");

        // Denormal vs normal with minimal exponent: both treated as exponent 1
        send(32'h00800000, 32'h00400000);
        expect_res("den", 2, 1'b0, 1'b0, 8'h01, 24'h800000, 27'h2000000, 8'h00, 1'b0);
        handshake("den");

        // Infinity operand sets special; shifting still runs
        send(32'h7F800000, 32'h3F800000);
        expect_res("inf", 9, 1'b0, 1'b0, 8'hFF, 24'h800000, 27'h0000001, 8'h80, 1'b1);
        handshake("inf");

        // Hold in DONE with a competing in_valid
        send(32'h3F800000, 32'h3F000000);
        expect_res("hold", 3, 1'b0, 1'b0, 8'h7F, 24'h800000, 27'h2000000, 8'h01, 1'b0);
        a = 32'h40000000; b = 32'h3F800000; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid",    {31'b0, out_valid}, 32'd1);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            check("hold_small",    {5'b0, small_mant}, 32'h2000000);
            check("hold_exp_diff", {24'b0, exp_diff}, 32'h01);
        end
        // in_valid stays high through the handshake cycle; must not be taken
        handshake("hold");
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("hold_no_accept", {31'b0, in_ready}, 32'd1);

        // Reset in the middle of SHIFT aborts the op
        a = 32'h3F800000; b = 32'h2B800000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_pre_valid", {31'b0, out_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_valid",    {31'b0, out_valid}, 32'd0);
        check("abort_small",    {5'b0, small_mant}, 32'd0);
        check("abort_exp_diff", {24'b0, exp_diff}, 32'd0);
        check("abort_big_exp",  {24'b0, big_exp}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("abort_ready", {31'b0, in_ready}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_result", {31'b0, out_valid}, 32'd0);

        send(32'h3F000000, 32'hBF800000);
        expect_res("post", 3, 1'b1, 1'b1, 8'h7F, 24'h800000, 27'h2000000, 8'h01, 1'b0);
        handshake("post");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
